// File: rtl/pacman_death_sequencer.sv
// Death / respawn / game-over sequencer for Pacman: sequences the death animation,
// strikes a heart, respawns the movers and covers them with a READY pause and invulnerability.
module pacman_death_sequencer #(
  parameter int unsigned DEATH_FRAMES   = 64,
  parameter int unsigned RESPAWN_FRAMES = 32,
  parameter int unsigned INVULN_FRAMES  = 96,
  parameter int unsigned START_LIVES    = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       collision,
  input  logic       newGame,
  output logic       strike,
  output logic       respawn,
  output logic       freeze,
  output logic       invulnerable,
  output logic [2:0] deathAnimFrame,
  output logic [1:0] livesLeft,
  output logic       gameOver
);

  typedef enum logic [2:0] {
    PLAY,
    DYING,
    STRIKE,
    RESPAWN,
    READY,
    INVULN,
    GAME_OVER
  } state_e;

  localparam logic [7:0] DEATH_LAST   = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] INVULN_LAST  = 8'(INVULN_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT   = 2'(START_LIVES);

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] lives_q, lives_d;
  logic       entry_q, entry_d;

  logic       strike_q, strike_d;
  logic       respawn_q, respawn_d;
  logic       freeze_q, freeze_d;
  logic       invuln_q, invuln_d;
  logic       game_over_q, game_over_d;
  logic [2:0] anim_q, anim_d;

  logic       count_en;
  logic [7:0] frame_cnt_inc;

  // A frame pulse landing on the first cycle of a state is not counted.
  assign count_en      = startOfFrame && !entry_q;
  assign frame_cnt_inc = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    lives_d     = lives_q;

    unique case (state_q)
      PLAY: begin
        if (collision) begin
          state_d     = DYING;
          frame_cnt_d = 8'd0;
        end
      end
      DYING: begin
        if (count_en) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_q == DEATH_LAST) begin
            state_d = STRIKE;
            lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          end
        end
      end
      STRIKE: begin
        state_d = (lives_q == 2'd0) ? GAME_OVER : RESPAWN;
      end
      RESPAWN: begin
        state_d     = READY;
        frame_cnt_d = 8'd0;
      end
      READY: begin
        if (count_en) begin
          if (frame_cnt_q == RESPAWN_LAST) begin
            state_d     = INVULN;
            frame_cnt_d = 8'd0;
          end else begin
            frame_cnt_d = frame_cnt_inc;
          end
        end
      end
      INVULN: begin
        if (count_en) begin
          if (frame_cnt_q == INVULN_LAST) begin
            state_d     = PLAY;
            frame_cnt_d = 8'd0;
          end else begin
            frame_cnt_d = frame_cnt_inc;
          end
        end
      end
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = PLAY;
    endcase

    // Restart overrides everything, including a pending strike.
    if (newGame) begin
      state_d     = READY;
      frame_cnt_d = 8'd0;
      lives_d     = LIVES_INIT;
    end

    entry_d = (state_d != state_q) || newGame;

    // Outputs are decoded from the next state so they come straight out of flops.
    strike_d    = (state_d == STRIKE);
    respawn_d   = (state_d == RESPAWN) || newGame;
    freeze_d    = (state_d != PLAY) && (state_d != INVULN);
    invuln_d    = (state_d != PLAY);
    game_over_d = (state_d == GAME_OVER);
    if (state_d != DYING)            anim_d = 3'd0;
    else if (frame_cnt_d > 8'd63)    anim_d = 3'd7;
    else                             anim_d = frame_cnt_d[5:3];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= PLAY;
      frame_cnt_q <= 8'd0;
      lives_q     <= LIVES_INIT;
      entry_q     <= 1'b0;
      strike_q    <= 1'b0;
      respawn_q   <= 1'b0;
      freeze_q    <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
      anim_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      lives_q     <= lives_d;
      entry_q     <= entry_d;
      strike_q    <= strike_d;
      respawn_q   <= respawn_d;
      freeze_q    <= freeze_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
      anim_q      <= anim_d;
    end
  end

  assign strike         = strike_q;
  assign respawn        = respawn_q;
  assign freeze         = freeze_q;
  assign invulnerable   = invuln_q;
  assign deathAnimFrame = anim_q;
  assign livesLeft      = lives_q;
  assign gameOver       = game_over_q;

endmodule

// File: tb/tb_pacman_death_sequencer.sv
// Directed self-checking bench for pacman_death_sequencer with default parameters.
module tb_pacman_death_sequencer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       collision;
  logic       newGame;
  logic       strike;
  logic       respawn;
  logic       freeze;
  logic       invulnerable;
  logic [2:0] deathAnimFrame;
  logic [1:0] livesLeft;
  logic       gameOver;

  int n_checks = 0;
  int n_fail   = 0;
  int strike_cnt  = 0;
  int respawn_cnt = 0;
  int both_cnt    = 0;
  int s_base;
  int r_base;

  pacman_death_sequencer dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .collision     (collision),
    .newGame       (newGame),
    .strike        (strike),
    .respawn       (respawn),
    .freeze        (freeze),
    .invulnerable  (invulnerable),
    .deathAnimFrame(deathAnimFrame),
    .livesLeft     (livesLeft),
    .gameOver      (gameOver)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (strike)             strike_cnt++;
    if (respawn)            respawn_cnt++;
    if (strike && respawn)  both_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  // From PLAY: one-cycle collision, then a full death animation ending in STRIKE.
  task automatic die_to_strike();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();
    repeat (64) pulse_sof();
  endtask

  // From the first READY cycle back to PLAY.
  task automatic ready_to_play();
    tick();
    repeat (32) pulse_sof();
    tick();
    repeat (96) pulse_sof();
  endtask

  task automatic recover();
    tick();
    tick();
    ready_to_play();
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; collision = 1'b0; newGame = 1'b0;
    #12;
    check("rst_strike", strike, 0);
    check("rst_respawn", respawn, 0);
    check("rst_freeze", freeze, 0);
    check("rst_invuln", invulnerable, 0);
    check("rst_gameover", gameOver, 0);
    check("rst_anim", deathAnimFrame, 0);
    check("rst_lives", livesLeft, 3);
    resetN = 1'b1;
    tick();
    check("play_freeze", freeze, 0);

    // Death 1: collision held 10 cycles, frame pulse on collision cycle and on DYING entry
    collision = 1'b1; startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("dying_freeze", freeze, 1);
    check("dying_invuln", invulnerable, 1);
    check("dying_anim0", deathAnimFrame, 0);
    pulse_sof();
    check("entry_sof_ignored", deathAnimFrame, 0);
    repeat (8) tick();
    collision = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      pulse_sof();
      if (k == 7 || k == 8 || k == 16 || k == 40 || k == 55 || k == 56 || k == 63)
        check($sformatf("anim_after_%0d", k), deathAnimFrame, 8'(k / 8));
    end
    check("no_early_strike", 8'(strike_cnt), 0);
    pulse_sof();
    check("strike_pulse", strike, 1);
    check("strike_lives", livesLeft, 2);
    check("strike_no_respawn", respawn, 0);
    check("strike_anim0", deathAnimFrame, 0);
    tick();
    check("strike_one_cycle", strike, 0);
    check("respawn_pulse", respawn, 1);
    tick();
    check("respawn_one_cycle", respawn, 0);
    check("ready_freeze", freeze, 1);
    collision = 1'b1;
    tick();
    repeat (31) pulse_sof();
    check("ready_freeze_31", freeze, 1);
    pulse_sof();
    check("invuln_freeze", freeze, 0);
    check("invuln_invuln", invulnerable, 1);
    tick();
    repeat (95) pulse_sof();
    check("invuln_95", invulnerable, 1);
    collision = 1'b0;
    pulse_sof();
    check("play_invuln", invulnerable, 0);
    check("play_freeze2", freeze, 0);
    check("one_strike_total", 8'(strike_cnt), 1);
    check("lives_after_d1", livesLeft, 2);

    // Deaths 2 and 3 to GAME_OVER
    die_to_strike();
    check("d2_lives", livesLeft, 1);
    recover();
    check("d2_back_play", invulnerable, 0);
    r_base = respawn_cnt;
    die_to_strike();
    check("d3_strike", strike, 1);
    check("d3_lives", livesLeft, 0);
    tick();
    check("go_gameover", gameOver, 1);
    check("go_freeze", freeze, 1);
    check("go_invuln", invulnerable, 1);
    repeat (3) tick();
    s_base = strike_cnt;
    collision = 1'b1;
    repeat (3) pulse_sof();
    collision = 1'b0;
    repeat (3) tick();
    check("go_hold", gameOver, 1);
    check("go_lives_hold", livesLeft, 0);
    check("go_no_strike", 8'(strike_cnt - s_base), 0);
    check("go_no_respawn", 8'(respawn_cnt - r_base), 0);

    // newGame from GAME_OVER
    r_base = respawn_cnt;
    s_base = strike_cnt;
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    check("ng_respawn", respawn, 1);
    check("ng_lives", livesLeft, 3);
    check("ng_gameover", gameOver, 0);
    check("ng_freeze", freeze, 1);
    tick();
    check("ng_respawn_once", 8'(respawn_cnt - r_base), 1);
    ready_to_play();
    check("ng_play", invulnerable, 0);
    check("ng_no_strike", 8'(strike_cnt - s_base), 0);

    // newGame coincident with collision in PLAY after losing a life
    die_to_strike();
    recover();
    check("pre_ng_lives", livesLeft, 2);
    r_base = respawn_cnt;
    s_base = strike_cnt;
    collision = 1'b1; newGame = 1'b1;
    tick();
    collision = 1'b0; newGame = 1'b0;
    check("ngc_respawn", respawn, 1);
    check("ngc_lives", livesLeft, 3);
    check("ngc_anim", deathAnimFrame, 0);
    tick();
    repeat (32) pulse_sof();
    check("ngc_is_ready", freeze, 0);
    check("ngc_invuln", invulnerable, 1);
    tick();
    repeat (96) pulse_sof();
    check("ngc_respawn_once", 8'(respawn_cnt - r_base), 1);
    check("ngc_no_strike", 8'(strike_cnt - s_base), 0);

    // Reset mid-DYING at frame 20
    die_to_strike();
    recover();
    check("pre_rst_lives", livesLeft, 2);
    collision = 1'b1;
    tick();
    collision = 1'b0;
    tick();
    repeat (20) pulse_sof();
    check("mid_anim", deathAnimFrame, 2);
    s_base = strike_cnt;
    r_base = respawn_cnt;
    #2 resetN = 1'b0;
    #1;
    check("arst_freeze", freeze, 0);
    check("arst_invuln", invulnerable, 0);
    check("arst_anim", deathAnimFrame, 0);
    check("arst_lives", livesLeft, 3);
    check("arst_strike", strike, 0);
    check("arst_gameover", gameOver, 0);
    #2 resetN = 1'b1;
    tick();
    repeat (70) pulse_sof();
    check("post_rst_no_strike", 8'(strike_cnt - s_base), 0);
    check("post_rst_no_respawn", 8'(respawn_cnt - r_base), 0);
    check("post_rst_play", freeze, 0);
    check("never_both", 8'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
